// File: rtl/mips_register_bank.sv
// ----------------------------------------------------------------------------
// mips_register_bank
//
// MIPS general-purpose register file for the ID stage, written back from WB.
// It has two combinational read ports and one synchronous write port.
// Register 0 is hardwired to zero.
//
// Ports:
//   i_clock       single clock; all state updates on the rising edge
//   i_reset       synchronous, active-high; clears every register
//   i_reg_write   write enable
//   i_jr_jalr     ID-stage JR/JALR flag; enables same-cycle forwarding on port A
//   i_read_reg_a  port A read address (rs)
//   i_read_reg_b  port B read address (rt)
//   i_write_reg   write address (rd/rt/31)
//   i_write_data  write data
//   o_data_a      contents of reg[i_read_reg_a]
//   o_data_b      contents of reg[i_read_reg_b]
//
// Configuration macro:
//   REGBANK_BYPASS_EN  defined   -> write-through forwarding on both ports,
//                                   independent of i_jr_jalr
//                      undefined -> port A forwards only while i_jr_jalr=1;
//                                   port B always returns stored contents
//
// BANK_DEPTH must equal 2**NB_ADDR, so every address maps to a register.
// ----------------------------------------------------------------------------
module mips_register_bank #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_reg_write,
    input  logic               i_jr_jalr,
    input  logic [NB_ADDR-1:0] i_read_reg_a,
    input  logic [NB_ADDR-1:0] i_read_reg_b,
    input  logic [NB_ADDR-1:0] i_write_reg,
    input  logic [NB_DATA-1:0] i_write_data,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b
);

`ifdef REGBANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [NB_DATA-1:0] regs [BANK_DEPTH];

    // A write takes effect only outside reset and never to register 0.
    // The forwarding paths use the same qualifier, so a forwarded value
    // is always one that will actually land in the array.
    logic wr_valid;
    logic fwd_a;
    logic fwd_b;

    assign wr_valid = i_reg_write && !i_reset && (i_write_reg != '0);

    // Port A forwards for JR/JALR so a jump target sees a WB result that
    // is written in this same cycle. With the bypass build both ports
    // forward unconditionally.
    assign fwd_a = wr_valid && (i_write_reg == i_read_reg_a) && (BYPASS || i_jr_jalr);
    assign fwd_b = wr_valid && (i_write_reg == i_read_reg_b) && BYPASS;

    // NOTE: sequential state uses non-blocking (<=) assignments. All
    // registers then update together at the edge, independent of
    // statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the whole array is reset by a loop. This is a choice,
            // because reset must clear every register. It also keeps the
            // array as flops rather than a RAM macro without reset.
            for (int i = 0; i < BANK_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[i_write_reg] <= i_write_data;
        end
    end

    // Read priority: address 0 -> zero, then forwarded data, then stored data.
    // The explicit zero check makes reg[0] read 0 even before the first reset.
    always_comb begin
        // NOTE: each output gets a default first. The if-chain below then
        // never leaves an output unassigned, so no latch is inferred.
        o_data_a = regs[i_read_reg_a];
        if (fwd_a) begin
            o_data_a = i_write_data;
        end
        if (i_read_reg_a == '0) begin
            o_data_a = '0;
        end

        o_data_b = regs[i_read_reg_b];
        if (fwd_b) begin
            o_data_b = i_write_data;
        end
        if (i_read_reg_b == '0) begin
            o_data_b = '0;
        end
    end

endmodule

// File: tb/tb_mips_register_bank.sv
// ----------------------------------------------------------------------------
// tb_mips_register_bank
//
// Self-checking bench for mips_register_bank.
// It runs directed scenarios: reset, plain writes, register 0, JR/JALR
// forwarding and reset while the bank is loaded. A randomized run follows.
// Expected read values come from an array model of the 32 registers and
// the forwarding rules.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_mips_register_bank;

    logic        clk;
    logic        rst;
    logic        we;
    logic        jr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] da;
    logic [31:0] db;

    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    mips_register_bank #(
        .NB_DATA   (32),
        .NB_ADDR   (5),
        .BANK_DEPTH(32)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_reg_write (we),
        .i_jr_jalr   (jr),
        .i_read_reg_a(ra),
        .i_read_reg_b(rb),
        .i_write_reg (wa),
        .i_write_data(wd),
        .o_data_a    (da),
        .o_data_b    (db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The value a read port must show, given the current inputs and the model.
    function automatic logic [31:0] expect_read(input logic [4:0] addr, input bit port_a);
        bit may_forward;
        if (addr == 5'd0) return 32'd0;
`ifdef REGBANK_BYPASS_EN
        may_forward = 1'b1;
`else
        may_forward = port_a && jr;
`endif
        if (!rst && we && wa != 5'd0 && wa == addr && may_forward) return wd;
        return model[addr];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic j,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] wr_addr, input logic [31:0] d);
        rst = r;
        we  = w;
        jr  = j;
        ra  = a;
        rb  = b;
        wa  = wr_addr;
        wd  = d;
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_a"}, da, expect_read(ra, 1'b1));
        check({tag, "_b"}, db, expect_read(rb, 1'b0));
    endtask

    // Advance one rising edge, apply the architectural effect to the model,
    // and return on the falling edge ready for the next stimulus.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom_range(1, 6));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);

        // 1) Two reset cycles. The write during reset is ignored, and
        //    reset also blocks forwarding.
        drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd31, 5'd10, 32'd123);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd10, 5'd10, 32'd77);
        check_ports("rst_no_fwd");
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 32'd0);
        check_ports("rst_r0_r10");
        drive(1'b0, 1'b0, 1'b0, 5'd31, 5'd10, 5'd0, 32'd0);
        check_ports("rst_r31");
        check("rst_r10_direct", db, 32'd0);

        // 2) Write 99 to reg 10. Without JR there is no same-cycle visibility.
        drive(1'b0, 1'b1, 1'b0, 5'd10, 5'd0, 5'd10, 32'd99);
        check_ports("wr10_same_cycle");
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd0);
        check_ports("rd10");
        check("rd10_direct", da, 32'd99);

        // 3) Write 555 to reg 1, then 111 to reg 31.
        drive(1'b0, 1'b1, 1'b0, 5'd2, 5'd3, 5'd1, 32'd555);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd2, 5'd3, 5'd31, 32'd111);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        check_ports("rd1_r0");
        drive(1'b0, 1'b0, 1'b0, 5'd31, 5'd1, 5'd0, 32'd0);
        check_ports("rd31_r1");

        // 4) A write to reg 0 is discarded, even with JR forwarding asserted.
        drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);
        check_ports("wr0_same_cycle");
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        check_ports("rd0_after");

        // 5) JR/JALR forwarding on port A. Port B depends on the bypass build.
        drive(1'b0, 1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 32'h0000_1234);
        check_ports("jr_fwd31");
`ifdef REGBANK_BYPASS_EN
        check("jr_fwd31_b_direct", db, 32'h0000_1234);
`else
        check("jr_fwd31_b_direct", db, 32'd111);
`endif
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 32'd0);
        check_ports("rd31_after_jr");

        // Randomized traffic with occasional resets and frequent address hits.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                  pick_addr(), pick_addr(), pick_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) ra = wa;
            if ($urandom_range(0, 3) == 0) rb = wa;
            check_ports("rand");
            tick();
        end

        // 6) Load every register, then one reset edge with a write pending.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'h0101_0101 * i + 32'd7);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd17, 5'd30, 5'd0, 32'd0);
        check_ports("loaded");
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 5'd5, 32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'd0);
            check_ports("post_rst_sweep");
            check("post_rst_direct", da, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
